// File: rtl/branch_predictor_if.sv
// Lookup (IF) and training (ID) bus of branch_predictor.
// Statistics signals exist only when BP_STATS_EN is defined.
interface bp_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_i;
  logic              hit_o;
  logic              taken_o;
  logic [ADDR_W-1:0] target_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              clear_i;
`ifdef BP_STATS_EN
  logic [31:0]       stat_lookups_o;
  logic [31:0]       stat_hits_o;
  logic [31:0]       stat_mispred_o;
`endif

  modport master (
    output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, clear_i,
    input  hit_o, taken_o, target_o
`ifdef BP_STATS_EN
    , input stat_lookups_o, stat_hits_o, stat_mispred_o
`endif
  );

  modport slave (
    input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, clear_i,
    output hit_o, taken_o, target_o
`ifdef BP_STATS_EN
    , output stat_lookups_o, stat_hits_o, stat_mispred_o
`endif
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with saturating direction counters: same-cycle lookup, one-cycle training.
// Optional lookup/hit/mispredict statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor #(
  parameter int ENTRIES        = 16,  // power of 2, >= 2
  parameter int ADDR_W         = 32,
  parameter int CTR_W          = 2,   // >= 1
  parameter int CTR_INIT_TAKEN = 1
) (
  input logic clk_i,
  input logic rst_i,
  bp_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX   = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK  = CTR_ONE << (CTR_W - 1);
  // For CTR_W = 1 both choices collapse to 1, the last-outcome "taken" value.
  localparam logic [CTR_W-1:0] CTR_ALLOC = (CTR_INIT_TAKEN != 0) ? CTR_WEAK : CTR_MAX;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];

  // ---------------- Lookup (IF stage, combinational) ----------------
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;

  assign w_lk_idx = bus.pc_i[IDX_W+1:2];
  assign w_lk_tag = bus.pc_i[ADDR_W-1:IDX_W+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign bus.hit_o    = w_lk_hit;
  assign bus.taken_o  = w_lk_hit && r_ctr[w_lk_idx][CTR_W-1];
  assign bus.target_o = w_lk_hit ? r_target[w_lk_idx] : '0;

  // Byte-offset bits never select an entry.
  logic [3:0] w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = {bus.pc_i[1:0], bus.upd_pc_i[1:0]};

  // ---------------- Training (ID stage) ----------------
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [CTR_W-1:0] w_up_cur;
  logic [CTR_W-1:0] w_up_ctr;
  logic             w_up_write;

  assign w_up_idx = bus.upd_pc_i[IDX_W+1:2];
  assign w_up_tag = bus.upd_pc_i[ADDR_W-1:IDX_W+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_cur = r_ctr[w_up_idx];

  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    w_up_ctr   = w_up_cur;
    w_up_write = 1'b0;
    if (w_up_hit) begin
      w_up_write = 1'b1;
      if (bus.upd_taken_i) begin
        w_up_ctr = (w_up_cur == CTR_MAX) ? w_up_cur : w_up_cur + CTR_ONE;
      end else begin
        w_up_ctr = (w_up_cur == '0) ? w_up_cur : w_up_cur - CTR_ONE;
      end
    end else if (bus.upd_taken_i) begin
      // Taken miss allocates, evicting any conflicting entry; not-taken misses are ignored.
      w_up_write = 1'b1;
      w_up_ctr   = CTR_ALLOC;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      // NOTE: the whole table is reset, not just the valid bits, so tags/targets/counters start at a known 0.
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else if (bus.clear_i) begin
      r_valid <= '0;
    end else if (bus.upd_valid_i && w_up_write) begin
      // NOTE: non-blocking writes mean a lookup in this cycle still sees the old entry (no bypass).
      r_valid[w_up_idx] <= 1'b1;
      r_tag[w_up_idx]   <= w_up_tag;
      r_ctr[w_up_idx]   <= w_up_ctr;
      if (bus.upd_taken_i) begin
        r_target[w_up_idx] <= bus.upd_target_i;
      end
    end
  end

`ifdef BP_STATS_EN
  // ---------------- Statistics ----------------
  logic        w_up_pred;
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_mispred;

  // Prediction the IF stage would have produced for the branch now being resolved.
  assign w_up_pred = w_up_hit && w_up_cur[CTR_W-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_lookups <= '0;
      r_stat_hits    <= '0;
      r_stat_mispred <= '0;
    end else begin
      if (r_stat_lookups != '1) begin
        r_stat_lookups <= r_stat_lookups + 32'd1;
      end
      if (w_lk_hit && (r_stat_hits != '1)) begin
        r_stat_hits <= r_stat_hits + 32'd1;
      end
      if (bus.upd_valid_i && (w_up_pred != bus.upd_taken_i) && (r_stat_mispred != '1)) begin
        r_stat_mispred <= r_stat_mispred + 32'd1;
      end
    end
  end

  assign bus.stat_lookups_o = r_stat_lookups;
  assign bus.stat_hits_o    = r_stat_hits;
  assign bus.stat_mispred_o = r_stat_mispred;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=16, CTR_W=2, weakly-taken allocation);
// directed cases use fixed expectations, the random phase uses a reference model; BP_STATS_EN adds stat checks.
module tb_branch_predictor;

  localparam int ADDR_W = 32;
  localparam int NENT   = 16;
  localparam int CMAX   = 3;
  localparam int CALLOC = 2;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t scb[$];

  bp_if #(.ADDR_W(ADDR_W)) bus ();

  branch_predictor #(
    .ENTRIES(NENT), .ADDR_W(ADDR_W), .CTR_W(2), .CTR_INIT_TAKEN(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model of the table, written from the behavioural description.
  bit          m_valid [NENT];
  logic [25:0] m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];
  longint      m_lookups, m_hits, m_mispred;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model_lookup(input logic [31:0] pc);
    exp_t e;
    int   i;
    i = int'(pc[5:2]);
    e.name  = "";
    e.hit   = m_valid[i] && (m_tag[i] == pc[31:6]);
    e.taken = e.hit && (m_ctr[i] >= 2);
    e.tgt   = e.hit ? m_tgt[i] : 32'h0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    m_lookups = 0; m_hits = 0; m_mispred = 0;
  endtask

  task automatic model_edge(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                            input bit ut, input logic [31:0] utgt, input bit clr, input bit rs);
    exp_t lk, up;
    int   i;
    if (rs) begin
      model_reset();
      return;
    end
    lk = model_lookup(pc);
    up = model_lookup(upc);
    if (m_lookups < 64'hFFFF_FFFF) m_lookups++;
    if (lk.hit && m_hits < 64'hFFFF_FFFF) m_hits++;
    if (uv && (up.taken != ut) && m_mispred < 64'hFFFF_FFFF) m_mispred++;
    if (clr) begin
      for (int k = 0; k < NENT; k++) m_valid[k] = 1'b0;
    end else if (uv) begin
      i = int'(upc[5:2]);
      if (up.hit) begin
        if (ut) begin
          m_ctr[i] = (m_ctr[i] == CMAX) ? CMAX : m_ctr[i] + 1;
          m_tgt[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ut) begin
        m_valid[i] = 1'b1; m_tag[i] = upc[31:6]; m_tgt[i] = utgt; m_ctr[i] = CALLOC;
      end
    end
  endtask

  // One clock cycle: drive, push expectation, sample at the falling edge, pop and compare.
  task automatic step(input string name, input logic [31:0] pc,
                      input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                      input bit clr, input bit rs,
                      input bit use_model, input bit ehit, input bit etaken, input logic [31:0] etgt);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = rs;
    bus.pc_i         = pc;
    bus.upd_valid_i  = uv;
    bus.upd_pc_i     = upc;
    bus.upd_taken_i  = ut;
    bus.upd_target_i = utgt;
    bus.clear_i      = clr;
    if (use_model) begin
      e = model_lookup(pc);
    end else begin
      e.hit = ehit; e.taken = etaken; e.tgt = etgt;
    end
    e.name = name;
    scb.push_back(e);
    @(negedge clk);
    e = scb.pop_front();
    check({e.name, "/hit"},    64'(bus.hit_o),    64'(e.hit));
    check({e.name, "/taken"},  64'(bus.taken_o),  64'(e.taken));
    check({e.name, "/target"}, 64'(bus.target_o), 64'(e.tgt));
`ifdef BP_STATS_EN
    check({e.name, "/stat_lookups"}, 64'(bus.stat_lookups_o), 64'(m_lookups));
    check({e.name, "/stat_hits"},    64'(bus.stat_hits_o),    64'(m_hits));
    check({e.name, "/stat_mispred"}, 64'(bus.stat_mispred_o), 64'(m_mispred));
`endif
    model_edge(pc, uv, upc, ut, utgt, clr, rs);
  endtask

  task automatic look(input string name, input logic [31:0] pc,
                      input bit h, input bit t, input logic [31:0] tg);
    step(name, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, h, t, tg);
  endtask

  task automatic look_upd(input string name, input logic [31:0] pc, input logic [31:0] upc,
                          input bit ut, input logic [31:0] utgt,
                          input bit h, input bit t, input logic [31:0] tg);
    step(name, pc, 1'b1, upc, ut, utgt, 1'b0, 1'b0, 1'b0, h, t, tg);
  endtask

  initial begin
    logic [31:0] p, up, tg;
    bit          uv, ut, clr, rs;

    bus.pc_i = '0; bus.upd_valid_i = 1'b0; bus.upd_pc_i = '0;
    bus.upd_taken_i = 1'b0; bus.upd_target_i = '0; bus.clear_i = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state and first allocation (lookup in the update cycle sees the old table).
    look    ("reset_0x40",      32'h40,                      1'b0, 1'b0, 32'h0);
    look_upd("alloc_same_cyc",  32'h40, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    look    ("alloc_next_cyc",  32'h40,                      1'b1, 1'b1, 32'h100);

    // Counter walk: 2 -> 1 -> 0 -> 0 (floor) -> 1 -> 2 -> 3 -> 3 (ceiling) -> 2.
    look_upd("nt_ctr2",   32'h40, 32'h40, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100);
    look_upd("nt_ctr1",   32'h40, 32'h40, 1'b0, 32'h0,   1'b1, 1'b0, 32'h100);
    look_upd("nt_ctr0",   32'h40, 32'h40, 1'b0, 32'h0,   1'b1, 1'b0, 32'h100);
    look_upd("t_ctr0",    32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 32'h100);
    look_upd("t_ctr1",    32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 32'h100);
    look_upd("t_ctr2",    32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 1'b1, 32'h100);
    look_upd("t_ctr3",    32'h40, 32'h40, 1'b1, 32'h104, 1'b1, 1'b1, 32'h100);
    look_upd("nt_sat3",   32'h40, 32'h40, 1'b0, 32'h999, 1'b1, 1'b1, 32'h104);
    look    ("after_sat", 32'h40,                        1'b1, 1'b1, 32'h104);

    // Aliasing on index 0, never-allocated not-taken branch, ignored byte offset.
    look_upd("alias_alloc", 32'h80, 32'h80, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    look    ("alias_old",   32'h40,                        1'b0, 1'b0, 32'h0);
    look    ("alias_new",   32'h80,                        1'b1, 1'b1, 32'h200);
    look_upd("nt_never",    32'h44, 32'h44, 1'b0, 32'h300, 1'b0, 1'b0, 32'h0);
    look    ("nt_never_lk", 32'h44,                        1'b0, 1'b0, 32'h0);
    look    ("pc_lsbs",     32'h82,                        1'b1, 1'b1, 32'h200);

    // Clear beats a coincident update; reset beats a coincident update.
    step("clear_upd", 32'h80, 1'b1, 32'h48, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
    look("clear_80",  32'h80, 1'b0, 1'b0, 32'h0);
    look("clear_48",  32'h48, 1'b0, 1'b0, 32'h0);
    look_upd("realloc", 32'h80, 32'h80, 1'b1, 32'h280, 1'b0, 1'b0, 32'h0);
    look("realloc_lk", 32'h80, 1'b1, 1'b1, 32'h280);
    step("rst_upd",   32'h80, 1'b1, 32'h80, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h280);
    look("rst_after", 32'h80, 1'b0, 1'b0, 32'h0);

    // Random phase against the reference model: 3 tags x 16 indices for frequent hits and aliasing.
    for (int n = 0; n < 400; n++) begin
      p   = (32'($urandom_range(1, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      up  = (32'($urandom_range(1, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      tg  = $urandom();
      uv  = ($urandom_range(0, 9) < 7);
      ut  = $urandom_range(0, 1) == 1;
      clr = ($urandom_range(0, 59) == 0);
      rs  = ($urandom_range(0, 149) == 0);
      step("rand", p, uv, up, ut, tg, clr, rs, 1'b1, 1'b0, 1'b0, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters. Replaces the static "predict not-taken, flush on resolve" scheme of the 5-stage pipeline.
- IF stage looks up the current PC and gets a same-cycle prediction and target for the PC mux.
- ID stage, where branches and jumps resolve, trains the table through a one-cycle write port.
- Tables are direct-mapped, tagged and flop-based. Depth and counter width are parameters.

Parameters:
- ENTRIES, 16, number of table entries; power of 2, minimum 2; IDX_W = log2(ENTRIES)
- ADDR_W, 32, PC and target width
- CTR_W, 2, direction counter width in bits, minimum 1
- CTR_INIT_TAKEN, 1, allocate with counter = weakly taken (1) or strongly taken (0)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous reset, active-high
- pc_i  in  ADDR_W  IF-stage PC to look up
- hit_o  out  1  valid entry with a matching tag exists for pc_i
- taken_o  out  1  predict taken: hit_o AND counter MSB set
- target_o  out  ADDR_W  stored target; 0 when hit_o = 0
- upd_valid_i  in  1  training write this cycle
- upd_pc_i  in  ADDR_W  PC of the resolved branch or jump
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  ADDR_W  actual taken target
- clear_i  in  1  invalidate the whole table (context flush)

Behaviour:
- Indexing:
  - index = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
  - pc[1:0] is ignored.
- Entry fields: valid, tag, target, ctr[CTR_W-1:0].
- Lookup is purely combinational from pc_i and current state (zero latency). hit_o, taken_o and target_o are functions of state and pc_i only, so they have no reset value of their own. After reset, all valid bits = 0, so hit_o = taken_o = 0 and target_o = 0 for any pc_i.
- Reset (rst_i = 1 at an edge):
  - All valid bits cleared.
  - All counters set to 0.
  - Targets and tags set to 0.
  - Overrides clear_i and upd_valid_i in the same cycle.
- clear_i (rst_i = 0): all valid bits cleared at the edge. Counters, tags and targets are kept. clear_i has priority over a coincident update, which is dropped.
- Update (upd_valid_i = 1, no reset or clear), with the entry selected by upd_pc_i:
  - Tag hit, taken: ctr = min(ctr+1, 2^CTR_W-1); target <= upd_target_i.
  - Tag hit, not taken: ctr = max(ctr-1, 0); target unchanged. Valid stays 1 even at ctr = 0.
  - Miss (invalid or tag mismatch), taken: allocate. valid <= 1, tag written, target <= upd_target_i, and ctr set as follows:
    - CTR_INIT_TAKEN = 1: ctr = 2^(CTR_W-1) (weakly taken).
    - CTR_INIT_TAKEN = 0: ctr = 2^CTR_W-1 (strongly taken).
    - A conflicting valid entry is overwritten.
  - Miss, not taken: no state change (not-taken branches are never allocated).
- Counters saturate and never wrap, in either direction.
- Simultaneous lookup and update of the same index: the lookup returns the pre-update contents. The new value is visible from the next cycle (write-after-read, no bypass).
- Only one update per cycle. No internal FSM; state is the table plus the optional statistics counters.
- CTR_W = 1: counter is a last-outcome bit. Taken allocation sets ctr = 1 regardless of CTR_INIT_TAKEN.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, the following are added:
  - Port stat_lookups_o (out, 32): increments every cycle, saturating at 2^32-1.
  - Port stat_hits_o (out, 32): increments every cycle hit_o = 1, saturating.
  - Port stat_mispred_o (out, 32): increments on each upd_valid_i cycle where the prediction made for upd_pc_i at the edge differs from upd_taken_i, saturating. That prediction is taken_o evaluated internally with upd_pc_i as the lookup PC; an untrained or never-allocated branch therefore predicts not taken.
  - All three counters are 0 on rst_i and unaffected by clear_i.
- When undefined, these ports and all related logic are absent.

Test Plan:
- Reset, then pc_i = 0x0000_0040 → hit_o = 0, taken_o = 0, target_o = 0.
- Update pc = 0x40, taken, target = 0x100 (ENTRIES = 16, CTR_W = 2, CTR_INIT_TAKEN = 1).
  - Same cycle lookup 0x40 → hit_o = 0.
  - Next cycle → hit_o = 1, taken_o = 1, target_o = 0x100 (ctr = 2).
- From ctr = 2 at 0x40:
  - Two not-taken updates → ctr = 0, taken_o = 0, hit_o = 1.
  - Third not-taken update → ctr stays 0.
  - Four taken updates → ctr saturates at 3, taken_o = 1.
- Aliasing: 0x40 allocated, then taken update at pc 0x80 (same index 0, different tag) with target 0x200.
  - Lookup 0x40 → hit_o = 0.
  - Lookup 0x80 → hit_o = 1, target_o = 0x200.
- Not-taken update at never-seen pc 0x44 → lookup 0x44 gives hit_o = 0.
- clear_i and upd_valid_i asserted in the same cycle → all entries invalid next cycle and the update is not applied.
- With BP_STATS_EN, same cycle rst_i = 1 → all outputs of reset state next cycle and stat counters = 0.
